ann_frame_loader: RTL and testbench
===================================

# ann_frame_loader

Sequential front-end for the combinational `top_ann_mem` classifier. It takes a serial stream of signed 16-bit EEG features, assembles them into an 8-feature frame and drives `f0`..`f7` with all eight values changing together. It then waits a fixed settle time, captures `predicted_stage` and returns it on a valid/ready output. It sits between the feature-extraction stream and the ANN, and is the single clocked wrapper around it.

## Interface

Parameters:
- `FEAT_W`, default 16: feature word width; must equal the ANN input width.
- `SETTLE_CYC`, default 4: cycles allowed for the ANN to settle; legal range 1..255.

Ports:
- `clk`, in, 1: single clock; all logic on the rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `s_valid`, in, 1: input feature beat is valid.
- `s_ready`, out, 1: loader accepts a feature beat.
- `s_data`, in, FEAT_W signed: feature value.
- `s_last`, in, 1: marks feature 7, the last beat of a frame.
- `f0`..`f7`, out, FEAT_W signed each: features driven to the ANN.
- `stage_in`, in, 2: `predicted_stage` from the ANN.
- `m_valid`, out, 1: result is valid.
- `m_ready`, in, 1: downstream accepts the result.
- `m_stage`, out, 2: captured stage.
- `frame_err`, out, 1: one-cycle pulse when a frame is rejected.
- `frame_cnt`, out, 16: number of frames completed.
- `err_cnt`, out, 16: number of frames rejected.

## Operation

- There are three states: LOAD, SETTLE and OUT.
- `s_ready` = (state == LOAD), decoded combinationally.
- **LOAD:**
  - Each beat (`s_valid && s_ready`) writes `s_data` into shadow register `sh[idx]`, then `idx++`.
  - The `f` outputs do not change during LOAD.
- **Frame check on every accepted beat:**
  - Error if `s_last == 1` with `idx != 7`, or `s_last == 0` with `idx == 7`.
  - On error: pulse `frame_err`, set `idx` to 0, discard the shadow contents, leave the `f` outputs unchanged, stay in LOAD.
- **Good beat 7:**
  - Copy all 8 registers in one edge: `sh[0..6]` plus the current `s_data` go to `f0..f7`.
  - `cnt <= SETTLE_CYC-1`, `idx <= 0`, go to SETTLE.
- **SETTLE:**
  - If `cnt == 0`: `m_stage <= stage_in`, `m_valid <= 1`, go to OUT.
  - Otherwise `cnt--`.
- **OUT:**
  - `m_valid` and `m_stage` are held stable until `m_ready`.
  - On `m_valid && m_ready`: `m_valid <= 0`, go to LOAD.
- The `f` outputs hold the last good frame indefinitely. The ANN therefore never sees a partial frame.
- Arithmetic:
  - Features pass through unmodified, with no sign or width change.
  - `cnt` is 8 bits.
  - `frame_cnt` and `err_cnt` wrap from 0xFFFF to 0.

## Timing

- **Reset values:** state LOAD, `idx` 0, `cnt` 0, `f0`..`f7` 0, `m_valid` 0, `m_stage` 0, `frame_err` 0, `frame_cnt` 0, `err_cnt` 0. `s_ready` is 1 in the first cycle after reset.
- **Reset mid-operation** (any state) discards the partial frame and any pending result.
- **Latency:**
  - The `f` outputs update on the edge that accepts beat 7.
  - `m_valid` rises `SETTLE_CYC` edges later.
  - `s_ready` returns 1 on the cycle after the `m_ready` handshake.
  - Minimum frame period with `m_ready` tied high is 8 + `SETTLE_CYC` + 1 cycles.
- `s_valid` without `s_ready` does not hold anything; upstream must keep the beat valid until accepted.
- `frame_err` is high for exactly the cycle after the rejecting edge.
- `frame_cnt` increments on the edge that sets `m_valid`.
- `err_cnt` increments on the same edge that sets `frame_err`.

## Configuration

- **Macro:** `ANN_LOADER_STATS_EN`.
- **Defined:** `frame_cnt` and `err_cnt` are live counters, as described above.
- **Undefined:**
  - Both counters are omitted and the ports are tied to 0.
  - `frame_err` still functions.
  - All other behaviour is identical.

## Structure

- Package `ann_pkg` holds:
  - `FEAT_W`, and `N_FEAT = 8`;
  - the `stage_t` typedef (2-bit; 0..3 = ANN sleep-stage classes);
  - the loader state enum `{LOAD, SETTLE, OUT}`.
- The block is a single module with no sub-module. The shadow array, index, settle counter and output registers fit in one FSM.
- The ANN (`top_ann_mem`) is instantiated by the parent, not by this block.

## Test plan

All scenarios use `SETTLE_CYC = 4` with `top_ann_mem` connected.

1. **Basic frame.** Stream 0,0,0,0,0,0,0,42 with `s_last` on beat 8.
   - `f7` = 42 and `f0`..`f6` = 0, all updated on the same edge.
   - `m_valid` rises 4 edges later, with `m_stage` equal to the ANN's `predicted_stage` for that vector.
   - `frame_cnt` = 1.
2. **Output backpressure.** Hold `m_ready` = 0 for 10 cycles after `m_valid`.
   - `m_valid` stays 1 and `m_stage` stays constant.
   - `s_ready` = 0 throughout, and the `f` outputs are unchanged.
   - `m_ready` = 1 gives `s_ready` = 1 on the next cycle.
3. **Early last.** Assert `s_last` on beat 3.
   - `frame_err` pulses for 1 cycle, `err_cnt` = 1, the `f` outputs keep the previous frame.
   - The next 8 beats (1..8) give `f0`..`f7` = 1..8.
4. **Missing last.** Beat 8 arrives with `s_last` = 0.
   - `frame_err` pulses, no SETTLE state is entered, `m_valid` stays 0.
5. **Reset mid-frame.** Apply `rst` after 5 beats.
   - All outputs go to their reset values and `s_ready` = 1.
   - A following full frame completes with correct latency.
6. **Statistics.** Send 3 good frames and 1 bad frame, with `s_valid` gaps between beats.
   - Macro defined: `frame_cnt` = 3, `err_cnt` = 1.
   - Macro undefined: both read 0, with the same `m_stage` sequence.

Source files
------------

// File: rtl/ann_pkg.sv
// ann_pkg: types and constants shared by the ANN front-end.
//   FEAT_W  : feature word width expected by the ANN inputs
//   N_FEAT  : features per frame
//   stage_t : ANN sleep-stage class (0..3)
//   loader_state_t : frame loader FSM states
package ann_pkg;

    localparam int FEAT_W = 16;
    localparam int N_FEAT = 8;

    typedef logic [1:0] stage_t;

    typedef enum logic [1:0] {
        LOAD   = 2'd0,
        SETTLE = 2'd1,
        OUT    = 2'd2
    } loader_state_t;

endpackage

// File: rtl/ann_frame_loader.sv
// ann_frame_loader: clocked front-end for the combinational top_ann_mem
// classifier. Serial signed features are collected into a shadow frame and
// presented on f0..f7 all at once. After SETTLE_CYC cycles the ANN's
// predicted_stage is captured and offered on a valid/ready output.
//
// Optional build macro: ANN_LOADER_STATS_EN
//   defined   : frame_cnt / err_cnt are live wrapping 16-bit counters
//   undefined : frame_cnt / err_cnt are tied to 0
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   s_valid/s_ready/s_data/s_last   feature beat stream (s_last = feature 7)
//   f0..f7                   frame driven to the ANN (last good frame)
//   stage_in                 predicted_stage from the ANN
//   m_valid/m_ready/m_stage  captured result
//   frame_err                one-cycle pulse per rejected beat
//   frame_cnt, err_cnt       completed / rejected frame counters
module ann_frame_loader #(
    parameter int FEAT_W     = ann_pkg::FEAT_W,
    parameter int SETTLE_CYC = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic signed [FEAT_W-1:0] s_data,
    input  logic                     s_last,
    output logic signed [FEAT_W-1:0] f0,
    output logic signed [FEAT_W-1:0] f1,
    output logic signed [FEAT_W-1:0] f2,
    output logic signed [FEAT_W-1:0] f3,
    output logic signed [FEAT_W-1:0] f4,
    output logic signed [FEAT_W-1:0] f5,
    output logic signed [FEAT_W-1:0] f6,
    output logic signed [FEAT_W-1:0] f7,
    input  logic [1:0]               stage_in,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [1:0]               m_stage,
    output logic                     frame_err,
    output logic [15:0]              frame_cnt,
    output logic [15:0]              err_cnt
);
    import ann_pkg::*;

    localparam logic [7:0] SETTLE_INIT = 8'(SETTLE_CYC - 1);
    localparam logic [2:0] LAST_IDX    = 3'(N_FEAT - 1);

    loader_state_t state_q, state_d;
    logic [2:0]    idx_q;
    logic [7:0]    cnt_q;
    stage_t        m_stage_q;
    logic          m_valid_q;
    logic          frame_err_q;

    // Shadow holds features 0..6; feature 7 goes straight from s_data to f7.
    logic signed [FEAT_W-1:0] sh_q [N_FEAT-1];
    logic signed [FEAT_W-1:0] f_q  [N_FEAT];

    logic last_slot;
    logic accept;
    logic beat_err;
    logic frame_done;
    logic capture;
    logic result_taken;

    always_comb begin
        state_d      = state_q;
        accept       = 1'b0;
        beat_err     = 1'b0;
        frame_done   = 1'b0;
        capture      = 1'b0;
        result_taken = 1'b0;
        last_slot    = (idx_q == LAST_IDX);
        unique case (state_q)
            LOAD: begin
                accept = s_valid;
                if (s_valid) begin
                    // s_last must coincide exactly with slot 7
                    if (s_last != last_slot) begin
                        beat_err = 1'b1;
                    end else if (s_last) begin
                        frame_done = 1'b1;
                        state_d    = SETTLE;
                    end
                end
            end
            SETTLE: begin
                if (cnt_q == 8'd0) begin
                    capture = 1'b1;
                    state_d = OUT;
                end
            end
            OUT: begin
                if (m_valid_q && m_ready) begin
                    result_taken = 1'b1;
                    state_d      = LOAD;
                end
            end
            default: state_d = LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= LOAD;
            idx_q       <= 3'd0;
            cnt_q       <= 8'd0;
            m_valid_q   <= 1'b0;
            m_stage_q   <= '0;
            frame_err_q <= 1'b0;
            for (int i = 0; i < N_FEAT; i++) begin
                f_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            frame_err_q <= beat_err;

            if (beat_err || frame_done) begin
                idx_q <= 3'd0;
            end else if (accept) begin
                idx_q <= idx_q + 3'd1;
            end

            if (frame_done) begin
                cnt_q <= SETTLE_INIT;
                for (int i = 0; i < N_FEAT - 1; i++) begin
                    f_q[i] <= sh_q[i];
                end
                f_q[N_FEAT-1] <= s_data;
            end else if (state_q == SETTLE && cnt_q != 8'd0) begin
                cnt_q <= cnt_q - 8'd1;
            end

            if (capture) begin
                m_stage_q <= stage_t'(stage_in);
                m_valid_q <= 1'b1;
            end else if (result_taken) begin
                m_valid_q <= 1'b0;
            end
        end
    end

    // Shadow is pure data; a rejected or reset frame is discarded by idx.
    always_ff @(posedge clk) begin
        if (accept && !last_slot) begin
            sh_q[idx_q] <= s_data;
        end
    end

`ifdef ANN_LOADER_STATS_EN
    logic [15:0] frame_cnt_q;
    logic [15:0] err_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt_q <= 16'd0;
            err_cnt_q   <= 16'd0;
        end else begin
            if (capture) begin
                frame_cnt_q <= frame_cnt_q + 16'd1;
            end
            if (beat_err) begin
                err_cnt_q <= err_cnt_q + 16'd1;
            end
        end
    end

    assign frame_cnt = frame_cnt_q;
    assign err_cnt   = err_cnt_q;
`else
    assign frame_cnt = 16'd0;
    assign err_cnt   = 16'd0;
`endif

    assign s_ready   = (state_q == LOAD);
    assign m_valid   = m_valid_q;
    assign m_stage   = m_stage_q;
    assign frame_err = frame_err_q;

    assign f0 = f_q[0];
    assign f1 = f_q[1];
    assign f2 = f_q[2];
    assign f3 = f_q[3];
    assign f4 = f_q[4];
    assign f5 = f_q[5];
    assign f6 = f_q[6];
    assign f7 = f_q[7];

endmodule

// File: tb/tb_ann_frame_loader.sv
// Testbench for ann_frame_loader: random and directed feature streams are
// fed through a frame-level reference model; expected results and errors are
// queued and a monitor compares them as the DUT presents them.
module tb_ann_frame_loader;

    localparam int SETTLE_CYC = 4;

    logic               clk = 1'b0;
    logic               rst;
    logic               s_valid;
    logic               s_ready;
    logic signed [15:0] s_data;
    logic               s_last;
    logic signed [15:0] f0, f1, f2, f3, f4, f5, f6, f7;
    logic [1:0]         stage_in;
    logic               m_valid;
    logic               m_ready;
    logic [1:0]         m_stage;
    logic               frame_err;
    logic [15:0]        frame_cnt;
    logic [15:0]        err_cnt;

    ann_frame_loader #(.FEAT_W(16), .SETTLE_CYC(SETTLE_CYC)) dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
        .f0(f0), .f1(f1), .f2(f2), .f3(f3), .f4(f4), .f5(f5), .f6(f6), .f7(f7),
        .stage_in(stage_in),
        .m_valid(m_valid), .m_ready(m_ready), .m_stage(m_stage),
        .frame_err(frame_err), .frame_cnt(frame_cnt), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Stand-in for the ANN: any deterministic function of the eight features.
    function automatic logic [1:0] ann_ref(input logic signed [15:0] v [8]);
        int s;
        s = 0;
        for (int i = 0; i < 8; i++) s += int'(v[i]) * (i + 1);
        return 2'(s) ^ {v[7][15], v[0][15]};
    endfunction

    logic signed [15:0] fv [8];
    assign fv[0] = f0; assign fv[1] = f1; assign fv[2] = f2; assign fv[3] = f3;
    assign fv[4] = f4; assign fv[5] = f5; assign fv[6] = f6; assign fv[7] = f7;
    always_comb stage_in = ann_ref(fv);

    function automatic logic [15:0] stat(input int c);
`ifdef ANN_LOADER_STATS_EN
        return 16'(c);
`else
        return 16'(c - c);
`endif
    endfunction

    // ---------------- reference model ----------------
    typedef struct {
        logic [1:0]  stage;
        logic [15:0] fcnt;
        int          lc;
    } res_t;

    res_t               res_q[$];
    logic [15:0]        err_q[$];
    int                 m_idx = 0;
    int                 m_frames = 0;
    int                 m_errs = 0;
    logic signed [15:0] m_sh [8];
    logic signed [15:0] exp_f [8];

    task automatic model_reset();
        m_idx = 0; m_frames = 0; m_errs = 0;
        for (int i = 0; i < 8; i++) exp_f[i] = '0;
        res_q.delete();
        err_q.delete();
    endtask

    task automatic model_beat(input logic signed [15:0] d, input logic l, input int lc);
        res_t r;
        if (l != (m_idx == 7)) begin
            m_errs++;
            err_q.push_back(stat(m_errs));
            m_idx = 0;
        end else if (l) begin
            m_sh[7] = d;
            for (int i = 0; i < 8; i++) exp_f[i] = m_sh[i];
            m_frames++;
            r.stage = ann_ref(m_sh);
            r.fcnt  = stat(m_frames);
            r.lc    = lc;
            res_q.push_back(r);
            m_idx = 0;
        end else begin
            m_sh[m_idx] = d;
            m_idx++;
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic send_beat(input logic signed [15:0] d, input logic l);
        int t;
        int lc;
        t = 0;
        s_valid = 1'b1; s_data = d; s_last = l;
        while (!s_ready && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (!s_ready) begin
            fail_now("beat_accept_timeout");
            s_valid = 1'b0;
            return;
        end
        lc = cyc;
        @(posedge clk);
        model_beat(d, l, lc);
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    task automatic gap(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while ((res_q.size() != 0 || m_valid) && t < 3000) begin
            @(negedge clk);
            t++;
        end
        if (res_q.size() != 0 || m_valid) fail_now("result_drain_timeout");
        gap(2);
    endtask

    // ---------------- m_ready driver ----------------
    int mr_mode = 0;   // 0 always high, 1 random, 2 hold low 10 cycles per result
    initial begin
        int   hold;
        logic pend;
        logic prev;
        hold = 0; pend = 1'b0; prev = 1'b0;
        m_ready = 1'b1;
        forever begin
            @(negedge clk);
            if (pend) begin
                chk("s_ready_after_handshake", s_ready, 1);
                chk("m_valid_after_handshake", m_valid, 0);
            end
            if (mr_mode == 2 && m_valid && !prev) hold = 10;
            prev = m_valid;
            if (hold > 0) begin
                m_ready = 1'b0;
                hold--;
            end else if (mr_mode == 1) begin
                m_ready = ($urandom_range(0, 3) != 0);
            end else begin
                m_ready = 1'b1;
            end
            pend = m_valid && m_ready && !rst;
        end
    end

    // ---------------- monitor ----------------
    initial begin
        res_t       r;
        logic       prev;
        logic [1:0] held;
        prev = 1'b0; held = 2'd0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                for (int i = 0; i < 8; i++) chk("f_frame", fv[i], exp_f[i]);
                chk("ready_while_valid", m_valid & s_ready, 0);
                if (m_valid && !prev) begin
                    if (res_q.size() == 0) begin
                        fail_now("unexpected_m_valid");
                    end else begin
                        r = res_q.pop_front();
                        chk("m_stage", m_stage, r.stage);
                        chk("frame_cnt_at_result", frame_cnt, r.fcnt);
                        chk("settle_latency", cyc - r.lc, SETTLE_CYC + 1);
                        held = m_stage;
                    end
                end else if (m_valid) begin
                    chk("m_stage_stable", m_stage, held);
                end
                if (frame_err) begin
                    if (err_q.size() == 0) fail_now("unexpected_frame_err");
                    else chk("err_cnt_at_err", err_cnt, err_q.pop_front());
                end
            end
            prev = m_valid;
        end
    end

    // ---------------- main sequence ----------------
    initial begin
        rst = 1'b1; s_valid = 1'b0; s_data = '0; s_last = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("reset_s_ready", s_ready, 1);
        chk("reset_m_valid", m_valid, 0);
        chk("reset_m_stage", m_stage, 0);
        chk("reset_frame_err", frame_err, 0);
        chk("reset_frame_cnt", frame_cnt, 0);
        chk("reset_err_cnt", err_cnt, 0);

        // basic frame
        for (int b = 0; b < 7; b++) send_beat(16'sd0, 1'b0);
        send_beat(16'sd42, 1'b1);
        wait_idle();
        chk("basic_frame_cnt", frame_cnt, stat(1));

        // output backpressure
        mr_mode = 2;
        for (int b = 0; b < 8; b++) send_beat(16'(-100 * b - 7), b == 7);
        wait_idle();
        mr_mode = 0;

        // early last on beat 3, then a clean 1..8 frame
        send_beat(16'sd5, 1'b0);
        send_beat(16'sd6, 1'b0);
        send_beat(16'sd7, 1'b1);
        gap(2);
        chk("early_last_err_cnt", err_cnt, stat(1));
        for (int b = 0; b < 8; b++) send_beat(16'(b + 1), b == 7);
        wait_idle();

        // missing last: eighth beat without s_last
        for (int b = 0; b < 8; b++) send_beat(16'(1000 + b), 1'b0);
        gap(SETTLE_CYC + 3);
        chk("missing_last_no_result", m_valid, 0);
        chk("missing_last_s_ready", s_ready, 1);

        // reset mid-frame
        for (int b = 0; b < 5; b++) send_beat(16'(-b), 1'b0);
        rst = 1'b1;
        @(posedge clk);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_s_ready", s_ready, 1);
        chk("midrst_m_valid", m_valid, 0);
        chk("midrst_f3", f3, 0);
        chk("midrst_err_cnt", err_cnt, 0);
        chk("midrst_frame_cnt", frame_cnt, 0);
        for (int b = 0; b < 8; b++) send_beat(16'(300 + b), b == 7);
        wait_idle();

        // statistics: 3 good + 1 bad with gaps
        for (int fr = 0; fr < 4; fr++) begin
            for (int b = 0; b < 8; b++) begin
                send_beat(16'($urandom), (fr == 2) ? 1'b0 : (b == 7));
                gap($urandom_range(0, 3));
            end
        end
        wait_idle();
        chk("stats_frame_cnt", frame_cnt, stat(m_frames));
        chk("stats_err_cnt", err_cnt, stat(m_errs));

        // randomized traffic
        mr_mode = 1;
        for (int fr = 0; fr < 40; fr++) begin
            int kind;
            int p;
            kind = $urandom_range(0, 5);
            p    = $urandom_range(0, 6);
            for (int b = 0; b < 8; b++) begin
                logic l;
                l = (b == 7);
                if (kind == 0 && b == p) begin
                    send_beat(16'($urandom), 1'b1);
                    break;
                end
                if (kind == 1 && b == 7) l = 1'b0;
                send_beat(16'($urandom), l);
                gap($urandom_range(0, 2));
            end
        end
        wait_idle();
        chk("final_frame_cnt", frame_cnt, stat(m_frames));
        chk("final_err_cnt", err_cnt, stat(m_errs));
        chk("final_err_queue_empty", err_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
